// File: rtl/ras_ckpt_stack_pkg.sv
// Shared types and constants for the return-address stack and its checkpoint table.
package ras_ckpt_stack_pkg;

  localparam int RAS_CKPT_NUM     = 8;
  localparam int RAS_TICKET_BITS  = $clog2(RAS_CKPT_NUM);  // width of predictor_update.ticket
  localparam int RAS_PTR_MAX_BITS = 8;                     // checkpoint fields cover depths up to 256
  localparam int RAS_CNT_MAX_BITS = 9;

  typedef struct packed {
    logic [RAS_PTR_MAX_BITS-1:0] tos;
    logic [RAS_CNT_MAX_BITS-1:0] count;
  } ras_ckpt_s;

endpackage

// File: rtl/ras_ckpt_table.sv
// Ticket-indexed checkpoint register file: one write port, one async read port.
module ras_ckpt_table
  import ras_ckpt_stack_pkg::*;
#(
  parameter int CKPT_NUM    = RAS_CKPT_NUM,
  parameter int TICKET_BITS = $clog2(CKPT_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   we_i,
  input  logic [TICKET_BITS-1:0] wr_ticket_i,
  input  ras_ckpt_s              wr_data_i,
  input  logic [TICKET_BITS-1:0] rd_ticket_i,
  output ras_ckpt_s              rd_data_o
);

  ras_ckpt_s slot_q [CKPT_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CKPT_NUM; i++) slot_q[i] <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < CKPT_NUM; i++) slot_q[i] <= '0;
    end else if (we_i) begin
      slot_q[wr_ticket_i] <= wr_data_i;
    end
  end

  // Read sees the pre-write value, so a same-cycle save+restore of one slot restores the old state.
  assign rd_data_o = slot_q[rd_ticket_i];

endmodule

// File: rtl/ras_ckpt_stack.sv
// Circular return-address stack with overflow wrap and one-cycle checkpoint restore.
module ras_ckpt_stack
  import ras_ckpt_stack_pkg::*;
#(
  parameter int PC_BITS     = 32,
  parameter int RAS_DEPTH   = 8,
  parameter int CKPT_NUM    = RAS_CKPT_NUM,
  parameter int TICKET_BITS = $clog2(CKPT_NUM),
  parameter int CNT_BITS    = $clog2(RAS_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [PC_BITS-1:0]     push_addr_i,
  input  logic                   pop_i,
  input  logic                   ckpt_save_i,
  input  logic [TICKET_BITS-1:0] ckpt_ticket_i,
  input  logic                   restore_i,
  input  logic [TICKET_BITS-1:0] restore_ticket_i,
  output logic                   top_valid_o,
  output logic [PC_BITS-1:0]     top_addr_o,
  output logic [CNT_BITS-1:0]    count_o,
  output logic                   overflow_o
);

  localparam int PTR_BITS = $clog2(RAS_DEPTH);

  logic [PC_BITS-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_BITS-1:0] tos_q, tos_d, tos_inc, tos_dec, wr_ptr;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                wr_en;
  logic                full, empty;
  ras_ckpt_s           save_data, restore_data;

  assign full  = (cnt_q == CNT_BITS'(RAS_DEPTH));
  assign empty = (cnt_q == '0);

  // Explicit wrap compares keep non-power-of-two depths correct.
  assign tos_inc = (tos_q == PTR_BITS'(RAS_DEPTH - 1)) ? '0 : tos_q + 1'b1;
  assign tos_dec = (tos_q == '0) ? PTR_BITS'(RAS_DEPTH - 1) : tos_q - 1'b1;

  always_comb begin
    save_data       = '0;
    save_data.tos   = RAS_PTR_MAX_BITS'(tos_q);
    save_data.count = RAS_CNT_MAX_BITS'(cnt_q);
  end

  ras_ckpt_table #(
    .CKPT_NUM    (CKPT_NUM),
    .TICKET_BITS (TICKET_BITS)
  ) u_ckpt_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (flush_i),
    .we_i        (ckpt_save_i && !flush_i),
    .wr_ticket_i (ckpt_ticket_i),
    .wr_data_i   (save_data),
    .rd_ticket_i (restore_ticket_i),
    .rd_data_o   (restore_data)
  );

  always_comb begin
    tos_d  = tos_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = tos_q;
    ovf_d  = 1'b0;
    if (flush_i) begin
      tos_d = '0;
      cnt_d = '0;
    end else if (restore_i) begin
      tos_d = PTR_BITS'(restore_data.tos);
      cnt_d = CNT_BITS'(restore_data.count);
    end else if (push_i && pop_i && !empty) begin
      // Return then call: replace the top in place.
      wr_en = 1'b1;
    end else if (push_i) begin
      tos_d  = tos_inc;
      wr_en  = 1'b1;
      wr_ptr = tos_inc;
      cnt_d  = full ? cnt_q : cnt_q + 1'b1;
      ovf_d  = full;
    end else if (pop_i && !empty) begin
      tos_d = tos_dec;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else if (wr_en) begin
      stack_q[wr_ptr] <= push_addr_i;
    end
  end

  assign top_valid_o = !empty;
  assign top_addr_o  = stack_q[tos_q];
  assign count_o     = cnt_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Scoreboard bench for ras_ckpt_stack at RAS_DEPTH=4.
module tb_ras_ckpt_stack;

  localparam int PC_BITS   = 32;
  localparam int RAS_DEPTH = 4;
  localparam int CKPT_NUM  = 8;
  localparam int TB_TICKET = $clog2(CKPT_NUM);
  localparam int TB_CNT    = $clog2(RAS_DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush_i, push_i, pop_i, ckpt_save_i, restore_i;
  logic [PC_BITS-1:0]   push_addr_i;
  logic [TB_TICKET-1:0] ckpt_ticket_i, restore_ticket_i;
  logic                 top_valid_o, overflow_o;
  logic [PC_BITS-1:0]   top_addr_o;
  logic [TB_CNT-1:0]    count_o;

  ras_ckpt_stack #(
    .PC_BITS   (PC_BITS),
    .RAS_DEPTH (RAS_DEPTH),
    .CKPT_NUM  (CKPT_NUM)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush_i),
    .push_i           (push_i),
    .push_addr_i      (push_addr_i),
    .pop_i            (pop_i),
    .ckpt_save_i      (ckpt_save_i),
    .ckpt_ticket_i    (ckpt_ticket_i),
    .restore_i        (restore_i),
    .restore_ticket_i (restore_ticket_i),
    .top_valid_o      (top_valid_o),
    .top_addr_o       (top_addr_o),
    .count_o          (count_o),
    .overflow_o       (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    int               cyc;
    logic             valid;
    logic [31:0]      addr;
    logic [TB_CNT-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   cycle_cnt = 0;
  int   checks    = 0;
  int   failures  = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic void compare(input string name, input logic v, input logic [31:0] a,
                                  input logic [TB_CNT-1:0] c, input logic o);
    checks++;
    if (top_valid_o !== v || top_addr_o !== a || count_o !== c || overflow_o !== o) begin
      failures++;
      $display("FAIL %s: got valid=%0b addr=%h count=%0d ovf=%0b, expected valid=%0b addr=%h count=%0d ovf=%0b",
               name, top_valid_o, top_addr_o, count_o, overflow_o, v, a, c, o);
    end
  endfunction

  // Monitor: compare each expectation on the falling edge of the cycle it targets.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
      e = sb.pop_front();
      if (e.cyc < cycle_cnt) begin
        checks++;
        failures++;
        $display("FAIL %s: observed at cycle %0d, required cycle %0d", e.name, cycle_cnt, e.cyc);
      end else begin
        compare(e.name, e.valid, e.addr, e.cnt, e.ovf);
      end
    end
  end

  task automatic op(input logic fl, input logic pu, input logic [31:0] pa, input logic po,
                    input logic sv, input logic [2:0] st, input logic rs, input logic [2:0] rt);
    @(negedge clk);
    flush_i = fl; push_i = pu; push_addr_i = pa; pop_i = po;
    ckpt_save_i = sv; ckpt_ticket_i = st; restore_i = rs; restore_ticket_i = rt;
  endtask

  task automatic expect_next(input string name, input logic v, input logic [31:0] a,
                             input int c, input logic o);
    exp_t e;
    e.name = name; e.cyc = cycle_cnt + 1; e.valid = v; e.addr = a;
    e.cnt = TB_CNT'(c); e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic idle();  op(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic push(input logic [31:0] a); op(0, 1, a, 0, 0, 0, 0, 0); endtask
  task automatic pop();   op(0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic flush(); op(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic save(input logic [2:0] t);    op(0, 0, 0, 0, 1, t, 0, 0); endtask
  task automatic restore(input logic [2:0] t); op(0, 0, 0, 0, 0, 0, 1, t); endtask

  initial begin
    rst_n = 1'b0;
    flush_i = 0; push_i = 0; push_addr_i = '0; pop_i = 0;
    ckpt_save_i = 0; ckpt_ticket_i = '0; restore_i = 0; restore_ticket_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle();            expect_next("reset",      0, 32'h0,   0, 0);

    push(32'h100);     expect_next("push100",    1, 32'h100, 1, 0);
    push(32'h200);     expect_next("push200",    1, 32'h200, 2, 0);
    push(32'h300);     expect_next("push300",    1, 32'h300, 3, 0);
    pop();             expect_next("pop_to200",  1, 32'h200, 2, 0);
    flush();           expect_next("flush1",     0, 32'h0,   0, 0);

    push(32'h10);      expect_next("ovf_p10",    1, 32'h10,  1, 0);
    push(32'h20);      expect_next("ovf_p20",    1, 32'h20,  2, 0);
    push(32'h30);      expect_next("ovf_p30",    1, 32'h30,  3, 0);
    push(32'h40);      expect_next("ovf_p40",    1, 32'h40,  4, 0);
    push(32'h50);      expect_next("ovf_p50",    1, 32'h50,  4, 1);
    pop();             expect_next("ovf_pop1",   1, 32'h40,  3, 0);
    pop();             expect_next("ovf_pop2",   1, 32'h30,  2, 0);
    pop();             expect_next("ovf_pop3",   1, 32'h20,  1, 0);
    pop();             expect_next("ovf_pop4",   0, 32'h50,  0, 0);
    pop();             expect_next("underflow",  0, 32'h50,  0, 0);

    flush();           expect_next("flush2",     0, 32'h40,  0, 0);
    push(32'hA0);      expect_next("ck_pA0",     1, 32'hA0,  1, 0);
    save(3);           expect_next("ck_save3",   1, 32'hA0,  1, 0);
    push(32'hB0);      expect_next("ck_pB0",     1, 32'hB0,  2, 0);
    push(32'hC0);      expect_next("ck_pC0",     1, 32'hC0,  3, 0);
    restore(3);        expect_next("ck_rest3",   1, 32'hA0,  1, 0);
    op(0, 1, 32'hD0, 0, 1, 5, 0, 0);
                       expect_next("ck_save_push", 1, 32'hD0, 2, 0);
    restore(5);        expect_next("ck_rest5",   1, 32'hA0,  1, 0);
    push(32'hE0);      expect_next("ck_pE0",     1, 32'hE0,  2, 0);
    op(0, 0, 0, 0, 1, 5, 1, 5);
                       expect_next("ck_save_rest_same", 1, 32'hA0, 1, 0);
    restore(5);        expect_next("ck_rest5_new", 1, 32'hE0, 2, 0);

    flush();           expect_next("flush3",     0, 32'h40,  0, 0);
    push(32'h100);     expect_next("pp_p100",    1, 32'h100, 1, 0);
    push(32'h200);     expect_next("pp_p200",    1, 32'h200, 2, 0);
    op(0, 1, 32'h300, 1, 0, 0, 0, 0);
                       expect_next("pushpop",    1, 32'h300, 2, 0);
    pop();             expect_next("pp_pop",     1, 32'h100, 1, 0);
    pop();             expect_next("pp_empty",   0, 32'h40,  0, 0);
    op(0, 1, 32'h77, 1, 0, 0, 0, 0);
                       expect_next("pushpop_empty", 1, 32'h77, 1, 0);

    op(1, 1, 32'h99, 0, 1, 6, 1, 3);
                       expect_next("flush_prio", 0, 32'h40,  0, 0);
    restore(3);        expect_next("post_fl_r3", 0, 32'h40,  0, 0);
    restore(6);        expect_next("post_fl_r6", 0, 32'h40,  0, 0);

    push(32'h11);      expect_next("rs_p11",     1, 32'h11,  1, 0);
    save(3);           expect_next("rs_save3",   1, 32'h11,  1, 0);
    push(32'h22);      expect_next("rs_p22",     1, 32'h22,  2, 0);
    idle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 compare("async_reset", 0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    restore(3);        expect_next("post_rst_r3", 0, 32'h0,  0, 0);
    idle();

    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ras_ckpt_stack.md
Name: ras_ckpt_stack

Overview:
- Parametrised return-address stack (RAS) for the superscalar IF stage.
- Generalises the fixed 8-entry RAS: circular buffer of RAS_DEPTH entries with overflow wrap.
- Adds ticket-indexed checkpoints so a branch misprediction restores stack state in one cycle.
- Sits beside the gshare/BTB predictors; the predictor_update ticket selects the checkpoint to restore.

Parameters:
PC_BITS, 32, width of stored return address
RAS_DEPTH, 8, number of stack entries (>=2, need not be power of two)
CKPT_NUM, 8, number of checkpoint slots (matches 3-bit ticket)
TICKET_BITS, $clog2(CKPT_NUM), derived, do not override
CNT_BITS, $clog2(RAS_DEPTH+1), derived, do not override

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  clear stack and all checkpoints
push_i  in  1  function call: push push_addr_i
push_addr_i  in  PC_BITS  return address (caller PC + 4/2, computed outside)
pop_i  in  1  function return: pop top
ckpt_save_i  in  1  save current tos/count into slot ckpt_ticket_i
ckpt_ticket_i  in  TICKET_BITS  slot to save
restore_i  in  1  misprediction: restore from slot restore_ticket_i
restore_ticket_i  in  TICKET_BITS  slot to restore
top_valid_o  out  1  count != 0
top_addr_o  out  PC_BITS  entry at tos (predicted return target)
count_o  out  CNT_BITS  live entries, saturates at RAS_DEPTH
overflow_o  out  1  registered 1-cycle pulse: a push overwrote the oldest entry

Behaviour:
- Reset (async assert, sync deassert): tos=0, count=0, all entries 0, all checkpoints {tos=0,count=0}, overflow_o=0.
- top_addr_o/top_valid_o: combinational from registers, zero latency; updates are visible the cycle after the operation.
- Priority per cycle: flush_i > restore_i > push/pop. A lower-priority operation in the same cycle is dropped entirely.
- flush_i: tos=0, count=0, checkpoints cleared; entry contents need not be cleared.
- restore_i: tos, count <= ckpt[restore_ticket_i]. Entry contents are not restored (accepted limitation: slots overwritten after the save return stale data).
  - A never-saved slot restores to empty.
- Push only: tos <= (tos+1) mod RAS_DEPTH, entry[new tos] <= push_addr_i, count <= min(count+1, RAS_DEPTH).
  - If count==RAS_DEPTH, the oldest entry is overwritten and overflow_o pulses next cycle.
- Pop only:
  - count>0: tos <= (tos-1) mod RAS_DEPTH, count-1.
  - count==0: no state change (underflow ignored), top_valid_o stays 0.
- Push+pop same cycle (return then call):
  - count>0: entry[tos] <= push_addr_i; tos and count unchanged.
  - count==0: behaves as push only.
- Wrap: explicit compare to RAS_DEPTH-1 / 0, so non-power-of-two depths are correct.
- ckpt_save_i: captures pre-update tos/count of the current cycle, independent of push/pop in that cycle.
  - Suppressed when flush_i is high.
  - Allowed alongside restore_i: the save writes the slot. If the same ticket is restored in that cycle, the restore uses the old slot value.
- overflow_o: cleared every cycle unless set by a push at full.

Decomposition:
- Into the shared package:
  - typedef ras_ckpt_s {tos [$clog2(RAS_DEPTH)-1:0], count [CNT_BITS-1:0]}
  - constants RAS_CKPT_NUM=8
  - ticket width tied to predictor_update.ticket
- Sub-module ras_ckpt_table: CKPT_NUM x ras_ckpt_s register file.
  - One write port (save) and one async read port (restore).
  - Reset/flush clears all slots.
- Stack array, pointer arithmetic and priority logic remain in ras_ckpt_stack.

Test Plan:
- DEPTH=4. Reset, push 0x100, 0x200, 0x300, then pop -> next cycle top_addr_o=0x200, count_o=2, top_valid_o=1.
- DEPTH=4. Push 0x10..0x50 (5 pushes) -> overflow_o pulses once, count_o=4. Four pops return 0x50, 0x40, 0x30, 0x20. A fifth pop leaves count_o=0, top_valid_o=0, no state change.
- Push 0xA0, save ticket 3, push 0xB0, push 0xC0, restore ticket 3 -> top_addr_o=0xA0, count_o=1.
- Stack holding [0x100,0x200]: push 0x300 with pop in the same cycle -> top_addr_o=0x300, count_o=2. Then pop -> 0x100.
- Restore, flush and push asserted in one cycle -> stack empty next cycle. A subsequent restore of any ticket -> count_o=0.
- Assert rst_n=0 mid-sequence, asynchronously off-edge -> outputs go to 0 immediately. After release, restore of ticket 3 -> empty.
